c17_bist_ctrl: RTL and testbench

C17_BIST_CTRL -- requirements
Module: c17_bist_ctrl

---
 rtl/c17_bist_pkg.sv | 30 +++
 rtl/c17_misr.sv | 19 +
 rtl/c17_bist_ctrl.sv | 86 ++++++++
 tb/tb_c17_bist_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/c17_bist_pkg.sv
// Shared types, widths and LFSR/MISR helpers for the c17 BIST controller.
// C17_BIST_ALLZERO_EN: extends the LFSR so that 00000 is also applied (N_PAT=32).
package c17_bist_pkg;
    localparam int PAT_W  = 5;
    localparam int RESP_W = 2;
    localparam int SIG_W  = 8;
`ifdef C17_BIST_ALLZERO_EN
    localparam int N_PAT  = 32;
`else
    localparam int N_PAT  = 31;
`endif
    // x^5+x^3+1 feeds back q[4]^q[2]; MISR taps s[7],s[5],s[4],s[3]
    localparam logic [PAT_W-1:0] LFSR_TAPS = 5'b10100;
    localparam logic [SIG_W-1:0] MISR_TAPS = 8'b1011_1000;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_APPLY, S_CAPTURE, S_DONE
    } state_t;

    function automatic logic [PAT_W-1:0] lfsr_next(input logic [PAT_W-1:0] q);
        logic fb;
        fb = ^(q & LFSR_TAPS);
`ifdef C17_BIST_ALLZERO_EN
        // de Bruijn extension: splice 00000 in between 10000 and 00001
        if (q[PAT_W-2:0] == '0)
            fb = ~fb;
`endif
        return {q[PAT_W-2:0], fb};
    endfunction
endpackage

// File: rtl/c17_misr.sv
// 8-bit multiple-input signature register compacting the c17 response.
// Behaviour does not depend on C17_BIST_ALLZERO_EN.
module c17_misr
    import c17_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [RESP_W-1:0] resp,
    output logic [SIG_W-1:0]  sig
);
    always_ff @(posedge clk) begin
        if (rst || clr)
            sig <= '0;
        else if (en)
            sig <= {sig[SIG_W-2:0], ^(sig & MISR_TAPS)} ^ {{(SIG_W-RESP_W){1'b0}}, resp};
    end
endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST controller for the ISCAS c17: LFSR stimulus, settle timing, MISR compaction.
// C17_BIST_ALLZERO_EN: also apply the all-zero pattern (32 patterns instead of 31).
module c17_bist_ctrl #(
    parameter int SETTLE_CYC = 1,
    parameter int SIG_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       seed,
    input  logic [SIG_W-1:0] golden_sig,
    output logic [4:0]       pattern,
    input  logic [1:0]       resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [5:0]       pat_cnt
);
    import c17_bist_pkg::*;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t     state, nxt;
    logic [3:0] settle;
    logic [5:0] cnt_inc;
    logic       last_pat;

    assign cnt_inc  = pat_cnt + 6'd1;
    assign last_pat = (cnt_inc == 6'(N_PAT));

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    if (start) nxt = S_LOAD;
            S_LOAD:    nxt = S_APPLY;
            S_APPLY:   if (settle == SETTLE_LAST) nxt = S_CAPTURE;
            S_CAPTURE: nxt = last_pat ? S_DONE : S_APPLY;
            S_DONE:    nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pattern <= '0;
            pat_cnt <= '0;
            pass    <= 1'b0;
            settle  <= '0;
        end else begin
            state <= nxt;
            case (state)
                S_LOAD: begin
                    pattern <= (seed == 5'd0) ? 5'd1 : seed;
                    pat_cnt <= '0;
                    pass    <= 1'b0;
                    settle  <= '0;
                end
                S_APPLY:
                    settle <= (settle == SETTLE_LAST) ? 4'd0 : settle + 4'd1;
                S_CAPTURE: begin
                    pat_cnt <= cnt_inc;
                    // the last pattern stays visible on the CUT after the run
                    if (!last_pat)
                        pattern <= lfsr_next(pattern);
                end
                S_DONE:
                    pass <= (signature == golden_sig);
                default: ;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    c17_misr u_misr (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == S_LOAD),
        .en   (state == S_CAPTURE),
        .resp (resp),
        .sig  (signature)
    );
endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Randomized self-checking bench for c17_bist_ctrl against a pattern-list reference model.
module tb_c17_bist_ctrl;
    localparam int SC = 1;
`ifdef C17_BIST_ALLZERO_EN
    localparam int NP = 32;
`else
    localparam int NP = 31;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] seed = '0;
    logic [7:0] golden_sig = '0;
    logic [4:0] pattern;
    logic [1:0] resp;
    logic       busy, done, pass;
    logic [7:0] signature;
    logic [5:0] pat_cnt;

    int total = 0;
    int bad   = 0;
    int mode  = 0;            // 0: resp tied 00, 1: c17 gates, 2: random table
    logic [1:0] rtab [32];
    logic [4:0] exp_pats [32];
    logic [7:0] exp_sig;

    always #5 clk = ~clk;

    c17_bist_ctrl #(.SETTLE_CYC(SC), .SIG_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .golden_sig(golden_sig),
        .pattern(pattern), .resp(resp), .busy(busy), .done(done), .pass(pass),
        .signature(signature), .pat_cnt(pat_cnt)
    );

    function automatic logic [1:0] c17f(input logic [4:0] p);
        logic g1, g2, g3, g6, g7, n10, n11, n16, n19;
        {g1, g2, g3, g6, g7} = p;
        n10 = ~(g1 & g3);
        n11 = ~(g3 & g6);
        n16 = ~(g2 & n11);
        n19 = ~(n11 & g7);
        return {~(n10 & n16), ~(n16 & n19)};
    endfunction

    function automatic logic [1:0] resp_of(input int m, input logic [4:0] p);
        if (m == 1) return c17f(p);
        if (m == 2) return rtab[p];
        return 2'b00;
    endfunction

    always_comb resp = resp_of(mode, pattern);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: list of applied patterns and the signature folded over them
    task automatic build_model(input logic [4:0] sd, input int m);
        logic [4:0] q;
        logic [7:0] s;
        logic       fb;
        q = (sd == 0) ? 5'd1 : sd;
        s = 8'h00;
        for (int k = 0; k < NP; k++) begin
            exp_pats[k] = q;
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ {6'b0, resp_of(m, q)};
            fb = q[4] ^ q[2];
            if (NP == 32 && q[3:0] == 4'b0000) fb = ~fb;
            q = {q[3:0], fb};
        end
        exp_sig = s;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " pattern"}, 32'(pattern), 32'd0);
        chk({tag, " signature"}, 32'(signature), 32'd0);
        chk({tag, " pat_cnt"}, 32'(pat_cnt), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " pass"}, 32'(pass), 32'd0);
    endtask

    // gbad=1 presents a golden signature one bit off the model
    task automatic run_bist(input logic [4:0] sd, input int m, input bit gbad, input bit poke);
        int  k;
        bit  seen;
        build_model(sd, m);
        mode = m;
        seed = sd;
        golden_sig = gbad ? (exp_sig ^ 8'h01) : exp_sig;
        @(negedge clk);
        start = 1'b1;
        k = 0;
        seen = 0;
        for (int c = 1; c <= 200 && !seen; c++) begin
            @(negedge clk);
            start = poke && (c % 13 == 0);
            if (c == 2 && busy !== 1'b1) chk("busy in run", 32'(busy), 32'd1);
            if (k < NP && c == 2 + k * (SC + 1)) begin
                chk($sformatf("pat[%0d]", k), 32'(pattern), 32'(exp_pats[k]));
                k++;
            end
            if (done) begin
                seen = 1;
                chk("done cycle", 32'(c), 32'(2 + NP * (SC + 1)));
                chk("signature", 32'(signature), 32'(exp_sig));
                chk("pat_cnt", 32'(pat_cnt), 32'(NP));
            end
        end
        start = 1'b0;
        if (!seen) chk("done timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("pass", 32'(pass), gbad ? 32'd0 : 32'd1);
        chk("idle busy", 32'(busy), 32'd0);
        chk("hold signature", 32'(signature), 32'(exp_sig));
        chk("hold pattern", 32'(pattern), 32'(exp_pats[NP-1]));
        repeat (3) @(negedge clk);
        chk("hold pass", 32'(pass), gbad ? 32'd0 : 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rtab[i] = 2'($urandom_range(0, 3));
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        run_bist(5'b00001, 1, 1'b0, 1'b0);   // c17 response, golden from model
        run_bist(5'b00001, 0, 1'b0, 1'b0);   // tied response, golden 00
        run_bist(5'b00001, 0, 1'b1, 1'b0);   // tied response, golden 01
        run_bist(5'b00000, 1, 1'b0, 1'b1);   // zero seed, start poked while busy
        for (int r = 0; r < 3; r++)
            run_bist(5'($urandom_range(0, 31)), 2, bit'($urandom_range(0, 1)), bit'(r == 1));

        // reset while pattern 10 is being applied
        build_model(5'b00101, 1);
        mode = 1;
        seed = 5'b00101;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pat10 before rst", 32'(pattern), 32'(exp_pats[10]));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("mid-run rst");
        run_bist(5'b00101, 1, 1'b0, 1'b0);

        // reset wins over start
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check_zero("rst+start");
        @(negedge clk);
        chk("rst+start idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
